// File: rtl/ahb_slave_if.sv
// AHB-Lite slave-side bus bundle; master drives address/control/write data, slave returns ready/resp/read data.
// Latency: none (wires only). Backpressure: hready from the master, hreadyout from the slave.
// Carries no state; modports fix the direction of each signal.
interface ahb_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [2:0]  hburst;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, hwrite, hsize, hprot, htrans, hmastlock, hburst, hready, hwdata,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, hwrite, hsize, hprot, htrans, hmastlock, hburst, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave.sv
// AHB word-addressed memory slave with SINGLE/INCR/WRAP bursts; AHB_SLAVE_ERR_RESP_EN adds out-of-range ERROR.
// Latency: one address edge, then one beat per hready edge; read data registered on its beat edge.
// Backpressure: hready=0 freezes all state; hreadyout drops only during the first ERROR cycle.
module ahb_slave #(
    parameter int DEPTH = 64
) (
    input  logic        hclk,
    input  logic        hresetn,
    ahb_slave_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

`ifdef AHB_SLAVE_ERR_RESP_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

    state_t          r_state;
    logic [AW-1:0]   r_cur;
    logic [3:0]      r_beat;
    logic            r_write;
    logic [2:0]      r_burst;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [DEPTH];

    logic [3:0]      w_nbeats_m1;
    logic            w_wrap;
    logic [AW-1:0]   w_mask;
    logic [AW-1:0]   w_cur_inc;
    logic [AW-1:0]   w_cur_nxt;
    logic            w_last;
    logic            w_unused;

    always_comb begin
        w_nbeats_m1 = 4'd0;
        case (r_burst[2:1])
            2'b00:   w_nbeats_m1 = 4'd0;
            2'b01:   w_nbeats_m1 = 4'd3;
            2'b10:   w_nbeats_m1 = 4'd7;
            default: w_nbeats_m1 = 4'd15;
        endcase
    end

    // Even non-zero burst codes are WRAP; INCR uses an all-ones mask so it wraps at DEPTH.
    assign w_wrap    = ~r_burst[0] & (r_burst[2:1] != 2'b00);
    assign w_mask    = w_wrap ? AW'(w_nbeats_m1) : {AW{1'b1}};
    assign w_cur_inc = r_cur + AW'(1);
    assign w_cur_nxt = (r_cur & ~w_mask) | (w_cur_inc & w_mask);
    assign w_last    = (r_beat == w_nbeats_m1);
    assign w_unused  = ^{bus.hsize, bus.hprot, bus.htrans, bus.hmastlock, bus.haddr[31:AW]};

`ifdef AHB_SLAVE_ERR_RESP_EN
    logic r_hreadyout;
    logic r_hresp;
    logic r_ovf;
    logic w_oob;
    logic w_top;

    assign w_oob = (bus.haddr >= 32'(DEPTH));
    // An INCR beat at the last word means the following beat would fall off the end of memory.
    assign w_top = (r_cur == {AW{1'b1}}) & ~w_wrap;
    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
`else
    assign bus.hreadyout = 1'b1;
    assign bus.hresp     = 1'b0;
`endif
    assign bus.hrdata = r_rdata;

    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_beat  <= '0;
            r_write <= 1'b0;
            r_burst <= 3'b000;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
`ifdef AHB_SLAVE_ERR_RESP_EN
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.hsel && bus.hready) begin
`ifdef AHB_SLAVE_ERR_RESP_EN
                        if (w_oob) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else begin
                            r_ovf <= 1'b0;
`endif
                            r_cur   <= bus.haddr[AW-1:0];
                            r_write <= bus.hwrite;
                            r_burst <= bus.hburst;
                            r_beat  <= '0;
                            r_state <= S_DATA;
`ifdef AHB_SLAVE_ERR_RESP_EN
                        end
`endif
                    end
                end
                S_DATA: begin
                    if (bus.hready) begin
`ifdef AHB_SLAVE_ERR_RESP_EN
                        if (r_ovf) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else begin
`endif
                            if (r_write) r_mem[r_cur] <= bus.hwdata;
                            else         r_rdata      <= r_mem[r_cur];
                            if (w_last) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_cur  <= w_cur_nxt;
                                r_beat <= r_beat + 4'd1;
`ifdef AHB_SLAVE_ERR_RESP_EN
                                r_ovf  <= w_top;
`endif
                            end
`ifdef AHB_SLAVE_ERR_RESP_EN
                        end
`endif
                    end
                end
`ifdef AHB_SLAVE_ERR_RESP_EN
                S_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_state     <= S_ERR2;
                end
                S_ERR2: begin
                    r_hresp <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_state <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_slave.sv
// Directed bench for ahb_slave: single, wait-state, INCR4, WRAP4, top-of-memory, reset mid-burst, out-of-range.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_ahb_slave;
    logic hclk;
    logic hresetn;
    int   n_checks;
    int   n_errors;

    ahb_slave_if bus ();

    ahb_slave #(.DEPTH(64)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] b);
        bus.hsel   = 1'b1;
        bus.hready = 1'b1;
        bus.haddr  = a;
        bus.hwrite = w;
        bus.hburst = b;
        bus.htrans = 2'b10;
        tick();
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
    endtask

    task automatic wbeat(input logic [31:0] d);
        bus.hready = 1'b1;
        bus.hwdata = d;
        tick();
    endtask

    task automatic rbeat(input string tag, input logic [31:0] exp);
        bus.hready = 1'b1;
        tick();
        chk(tag, bus.hrdata, exp);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        hresetn       = 1'b1;
        bus.hsel      = 1'b0;
        bus.haddr     = '0;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'b010;
        bus.hprot     = 4'b0011;
        bus.htrans    = 2'b00;
        bus.hmastlock = 1'b0;
        bus.hburst    = 3'b000;
        bus.hready    = 1'b1;
        bus.hwdata    = '0;

        tick();
        tick();
        chk("rst_hrdata", bus.hrdata, 32'd0);
        chk("rst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        chk("rst_hresp", {31'd0, bus.hresp}, 32'd0);
        hresetn = 1'b0;

        // single write then read
        addr_ph(32'd0, 1'b1, 3'b000);
        wbeat(32'd100);
        chk("single_wr_no_rdata", bus.hrdata, 32'd0);
        addr_ph(32'd0, 1'b0, 3'b000);
        rbeat("single_rd", 32'd100);
        chk("single_hresp", {31'd0, bus.hresp}, 32'd0);

        // wait states in address and data phase
        bus.hsel   = 1'b1;
        bus.haddr  = 32'd7;
        bus.hwrite = 1'b1;
        bus.hburst = 3'b000;
        bus.hwdata = 32'd7;
        bus.hready = 1'b0;
        tick();
        tick();
        bus.hready = 1'b1;
        tick();
        bus.hsel   = 1'b0;
        bus.hready = 1'b0;
        bus.hwdata = 32'd99;
        tick();
        tick();
        chk("ws_hold_rdata", bus.hrdata, 32'd100);
        wbeat(32'd7);
        addr_ph(32'd7, 1'b0, 3'b000);
        bus.hready = 1'b0;
        tick();
        chk("ws_rd_stall", bus.hrdata, 32'd100);
        rbeat("ws_rd", 32'd7);

        // INCR4
        addr_ph(32'd1, 1'b1, 3'b011);
        for (int i = 1; i <= 4; i++) wbeat(32'(i));
        addr_ph(32'd1, 1'b0, 3'b011);
        rbeat("incr4_rd0", 32'd1);
        rbeat("incr4_rd1", 32'd2);
        rbeat("incr4_rd2", 32'd3);
        rbeat("incr4_rd3", 32'd4);

        // WRAP4 from 1: 1,2,3,0
        addr_ph(32'd1, 1'b1, 3'b010);
        for (int i = 21; i <= 24; i++) wbeat(32'(i));
        addr_ph(32'd1, 1'b0, 3'b010);
        rbeat("wrap4_rd0", 32'd21);
        rbeat("wrap4_rd1", 32'd22);
        rbeat("wrap4_rd2", 32'd23);
        rbeat("wrap4_rd3", 32'd24);
        addr_ph(32'd4, 1'b0, 3'b000);
        rbeat("wrap4_word4_kept", 32'd4);

        // INCR4 starting two words below the top of memory
        addr_ph(32'd62, 1'b1, 3'b011);
        wbeat(32'hA0);
        wbeat(32'hA1);
`ifdef AHB_SLAVE_ERR_RESP_EN
        wbeat(32'hA2);
        chk("top_err1_hreadyout", {31'd0, bus.hreadyout}, 32'd0);
        chk("top_err1_hresp", {31'd0, bus.hresp}, 32'd1);
        tick();
        chk("top_err2_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        chk("top_err2_hresp", {31'd0, bus.hresp}, 32'd1);
        tick();
        chk("top_idle_hresp", {31'd0, bus.hresp}, 32'd0);
        addr_ph(32'd0, 1'b0, 3'b000);
        rbeat("top_word0_kept", 32'd24);
        addr_ph(32'd63, 1'b0, 3'b000);
        rbeat("top_word63", 32'hA1);
`else
        wbeat(32'hA2);
        wbeat(32'hA3);
        addr_ph(32'd62, 1'b0, 3'b011);
        rbeat("top_rd62", 32'hA0);
        rbeat("top_rd63", 32'hA1);
        rbeat("top_rd0", 32'hA2);
        rbeat("top_rd1", 32'hA3);
`endif

        // reset after two beats of an INCR4 write
        addr_ph(32'd8, 1'b1, 3'b011);
        wbeat(32'd5);
        wbeat(32'd6);
        hresetn = 1'b1;
        tick();
        chk("midrst_hrdata", bus.hrdata, 32'd0);
        chk("midrst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        hresetn    = 1'b0;
        bus.hready = 1'b1;
        bus.hwdata = 32'd77;
        tick();
        tick();
        addr_ph(32'd8, 1'b0, 3'b011);
        rbeat("midrst_rd8", 32'd0);
        rbeat("midrst_rd9", 32'd0);
        rbeat("midrst_rd10", 32'd0);
        rbeat("midrst_rd11", 32'd0);
        addr_ph(32'd0, 1'b0, 3'b000);
        rbeat("midrst_rd0", 32'd0);
        addr_ph(32'd3, 1'b1, 3'b000);
        wbeat(32'd55);
        addr_ph(32'd3, 1'b0, 3'b000);
        rbeat("midrst_new_rd", 32'd55);

        // address equal to DEPTH
        addr_ph(32'd64, 1'b1, 3'b000);
`ifdef AHB_SLAVE_ERR_RESP_EN
        chk("oob_err1_hreadyout", {31'd0, bus.hreadyout}, 32'd0);
        chk("oob_err1_hresp", {31'd0, bus.hresp}, 32'd1);
        bus.hwdata = 32'hDEAD;
        tick();
        chk("oob_err2_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        chk("oob_err2_hresp", {31'd0, bus.hresp}, 32'd1);
        tick();
        chk("oob_idle_hresp", {31'd0, bus.hresp}, 32'd0);
        addr_ph(32'd0, 1'b0, 3'b000);
        rbeat("oob_word0_kept", 32'd0);
`else
        wbeat(32'hDEAD);
        chk("oob_hresp", {31'd0, bus.hresp}, 32'd0);
        chk("oob_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        addr_ph(32'd0, 1'b0, 3'b000);
        rbeat("oob_hits_word0", 32'hDEAD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ahb_slave.md
AHB_SLAVE -- requirements
Module: ahb_slave

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit memory words; power of two; word index is haddr[log2(DEPTH)-1:0].
REQ-002 hclk  input  1  single clock; all state updates on its rising edge.
REQ-003 hresetn  input  1  reset; synchronous, active-high (asserted = 1), sampled on rising hclk.
REQ-004 hsel  input  1  slave select; qualifies address-phase capture.
REQ-005 haddr  input  32  word address (word index, not byte address).
REQ-006 hwrite  input  1  1 = write, 0 = read; latched at address capture.
REQ-007 hsize 3, hprot 4, htrans 2, hmastlock 1: inputs, accepted and ignored; every access is a full 32-bit word.
REQ-008 hburst  input  3  burst type; latched at address capture.
REQ-009 hready  input  1  bus ready; 0 stalls the slave, with no capture and no beat.
REQ-010 hwdata  input  32  write data, sampled in the data phase.
REQ-011 hreadyout  output  1  slave ready.
REQ-012 hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-013 hrdata  output  32  registered read data.

Function
REQ-014 Storage: DEPTH x 32-bit memory.
REQ-015 State machine has two states, IDLE and DATA.
REQ-016 IDLE: on an edge with hsel=1 and hready=1, capture haddr, hwrite and hburst, clear the beat counter, and go to DATA; otherwise stay in IDLE.
REQ-017 DATA, each edge with hready=1 is one beat. A write beat does mem[cur] <= hwdata. A read beat does hrdata <= mem[cur]. Then cur advances and the beat counter increments. hsel is ignored in DATA.
REQ-018 DATA with hready=0: hold all state, no memory access, hrdata unchanged.
REQ-019 Beats per burst: 000 SINGLE 1; 001 INCR 1 (each address phase is a one-beat transfer); 010 WRAP4 4; 011 INCR4 4; 100 WRAP8 8; 101 INCR8 8; 110 WRAP16 16; 111 INCR16 16.
REQ-020 INCR types advance cur by 1, wrapping modulo DEPTH at the top of memory.
REQ-021 WRAP-N types advance cur by 1 within the N-aligned block: next = (cur & ~(N-1)) | ((cur+1) & (N-1)).
REQ-022 After the last beat, return to IDLE; a new address phase is accepted no earlier than the following edge.
REQ-023 Read latency: hrdata is valid from the beat edge onward and holds its value until the next read beat.
REQ-024 A read of an address written on an earlier edge returns the new data; same-edge read/write of one word cannot occur.
REQ-025 Without ERR_RESP_EN: hreadyout=1 and hresp=0 at all times.

Reset
REQ-026 hresetn=1 at an edge: state=IDLE, beat counter=0, cur=0, hrdata=0, hreadyout=1, hresp=0, all memory words=0.
REQ-027 Reset mid-burst abandons the burst, and no further beats of it occur.

Configuration
REQ-028 Macro AHB_SLAVE_ERR_RESP_EN.
REQ-029 When defined: an address capture with haddr >= DEPTH performs no access and gives a two-cycle ERROR. Cycle 1: hreadyout=0, hresp=1. Cycle 2: hreadyout=1, hresp=1. Then IDLE.
REQ-030 When defined, a burst whose cur crosses DEPTH terminates with the same two-cycle ERROR at that beat.
REQ-031 When undefined: haddr is taken modulo DEPTH, and hresp=0 and hreadyout=1 always.

Verification
REQ-032 Single: write(addr 0, data 100), then read(addr 0) -> hrdata=100 one edge after the read data-phase edge; hresp=0.
REQ-033 Wait states: hsel=1, addr 7, data 7, hready=0 for 2 cycles, then hready=1 -> no write until hready=1; a later read of addr 7 returns 7.
REQ-034 INCR4 write: addr 1, then hwdata 1,2,3,4 on four data edges -> mem[1..4]=1..4. INCR4 read from addr 1 -> hrdata sequence 1,2,3,4.
REQ-035 WRAP4 write: addr 1, data 1,2,3,4 -> mem[1]=1, mem[2]=2, mem[3]=3, mem[0]=4. Read back in the same order.
REQ-036 Reset asserted after beat 2 of INCR4 -> IDLE, hrdata=0, memory all zero, next address phase accepted normally.
REQ-037 With AHB_SLAVE_ERR_RESP_EN, access to haddr=DEPTH -> hreadyout 0 then 1 with hresp=1 both cycles, memory unchanged. Without the macro, the access hits word 0.
